// File: rtl/adder_tree_pkg.sv
// Shared definitions for the pipelined adder tree.
//  - Default parameter constants (operand width, tree depth, LSB segment width).
//  - stage_tag_t: valid bit plus signed-mode tag carried alongside every stage.
//  - Width helpers: lvl_w gives the result width of level k and msb_w the width of its MSB add.
package adder_tree_pkg;

  localparam int unsigned DefW    = 12;
  localparam int unsigned DefLvls = 3;
  localparam int unsigned DefSeg  = 7;

  typedef struct packed {
    logic valid;
    logic sgn;
  } stage_tag_t;

  // Result width after level k (level 0 = raw operands).
  function automatic int unsigned lvl_w(input int unsigned w, input int unsigned k);
    return w + k;
  endfunction

  // Width of the MSB add performed in level k.
  function automatic int unsigned msb_w(input int unsigned w, input int unsigned k,
                                        input int unsigned seg);
    return w + k - seg;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One level of the pipelined adder tree: reduces 2*PAIRS operands of IW bits into PAIRS
// results of IW+1 bits over two register stages.
//  Stage 1: LSB add of bits [SEG-1:0] (SEG+1 bit result), MSBs of both operands delayed.
//  Stage 2: MSB add of the extended MSBs plus the registered LSB carry; LSB bits delayed.
// Ports:
//  clk_i, rst_ni  clock, synchronous active-low reset
//  en_i           advance; 0 = both stages hold
//  valid_i        incoming stage carries a sample
//  signed_i       sample mode tag (1 = two's complement)
//  data_i         2*PAIRS packed operands, operand i = data_i[i*IW +: IW]
//  valid_o        valid bit of the level result
//  signed_o       mode tag of the level result
//  data_o         PAIRS packed results, result p = data_o[p*(IW+1) +: IW+1]
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int unsigned IW    = 12,
  parameter int unsigned SEG   = 7,
  parameter int unsigned PAIRS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      valid_i,
  input  logic                      signed_i,
  input  logic [2*PAIRS*IW-1:0]     data_i,
  output logic                      valid_o,
  output logic                      signed_o,
  output logic [PAIRS*(IW+1)-1:0]   data_o
);

  localparam int unsigned MIW = IW - SEG;            // MSB slice width entering the level
  localparam int unsigned MOW = msb_w(IW, 1, SEG);   // MSB add width, MIW + 1
  localparam int unsigned OW  = IW + 1;

  stage_tag_t tag1_d, tag1_q, tag2_d, tag2_q;

  logic [SEG:0]     lsb1_d [PAIRS];
  logic [SEG:0]     lsb1_q [PAIRS];
  logic [MIW-1:0]   amsb1_d [PAIRS];
  logic [MIW-1:0]   amsb1_q [PAIRS];
  logic [MIW-1:0]   bmsb1_d [PAIRS];
  logic [MIW-1:0]   bmsb1_q [PAIRS];
  logic [MOW-1:0]   msb2_d [PAIRS];
  logic [MOW-1:0]   msb2_q [PAIRS];
  logic [SEG-1:0]   lsb2_d [PAIRS];
  logic [SEG-1:0]   lsb2_q [PAIRS];

  always_comb begin
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    lsb1_d  = lsb1_q;
    amsb1_d = amsb1_q;
    bmsb1_d = bmsb1_q;
    msb2_d  = msb2_q;
    lsb2_d  = lsb2_q;
    if (en_i) begin
      tag1_d = '{valid: valid_i, sgn: signed_i};
      tag2_d = tag1_q;
      for (int p = 0; p < int'(PAIRS); p++) begin
        lsb1_d[p]  = {1'b0, data_i[2*p*IW +: SEG]} + {1'b0, data_i[(2*p+1)*IW +: SEG]};
        amsb1_d[p] = data_i[2*p*IW + SEG +: MIW];
        bmsb1_d[p] = data_i[(2*p+1)*IW + SEG +: MIW];
        // Extension bit is the MSB only for signed samples, so one adder serves both modes.
        msb2_d[p]  = {tag1_q.sgn & amsb1_q[p][MIW-1], amsb1_q[p]}
                   + {tag1_q.sgn & bmsb1_q[p][MIW-1], bmsb1_q[p]}
                   + {{MIW{1'b0}}, lsb1_q[p][SEG]};
        lsb2_d[p]  = lsb1_q[p][SEG-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tag1_q <= '0;
      tag2_q <= '0;
      for (int p = 0; p < int'(PAIRS); p++) begin
        lsb1_q[p]  <= '0;
        amsb1_q[p] <= '0;
        bmsb1_q[p] <= '0;
        msb2_q[p]  <= '0;
        lsb2_q[p]  <= '0;
      end
    end else begin
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
      lsb1_q  <= lsb1_d;
      amsb1_q <= amsb1_d;
      bmsb1_q <= bmsb1_d;
      msb2_q  <= msb2_d;
      lsb2_q  <= lsb2_d;
    end
  end

  for (genvar g = 0; g < int'(PAIRS); g++) begin : g_out
    assign data_o[g*OW +: OW] = {msb2_q[g], lsb2_q[g]};
  end

  assign valid_o  = tag2_q.valid;
  assign signed_o = tag2_q.sgn;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined adder tree: sums N = 2**LVLS operands of W bits per sample, one sample per
// enabled clock, latency 2*LVLS enabled clocks. Each sample carries its own signed/unsigned
// mode; the result is exact in W+LVLS bits.
// Ports:
//  clk         rising-edge clock
//  rst_n       synchronous active-low reset, priority over en
//  en          pipeline advance; 0 = every stage holds
//  in_valid    in_data/in_signed carry a sample
//  in_signed   1 = operands two's complement, 0 = unsigned
//  in_data     N packed operands, operand i = in_data[i*W +: W]
//  out_valid   sum carries a result
//  sum         total of the N operands; holds its last value while out_valid=0
//  out_signed  mode tag of the sample on sum
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int unsigned W    = DefW,
  parameter int unsigned LVLS = DefLvls,
  parameter int unsigned SEG  = DefSeg
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic                      in_signed,
  input  logic [(1<<LVLS)*W-1:0]    in_data,
  output logic                      out_valid,
  output logic [W+LVLS-1:0]         sum,
  output logic                      out_signed
);

  localparam int unsigned N  = 1 << LVLS;
  localparam int unsigned OW = lvl_w(W, LVLS);

  if (SEG >= W || SEG < 1 || LVLS < 1) begin : g_param_err
    $error("adder_tree_pipe: need 1 <= SEG < W and LVLS >= 1");
  end

  for (genvar k = 1; k <= int'(LVLS); k++) begin : g_lvl
    localparam int unsigned IW    = lvl_w(W, k - 1);
    localparam int unsigned PAIRS = N >> k;

    logic [2*PAIRS*IW-1:0]   din;
    logic                    vin;
    logic                    sin;
    logic [PAIRS*(IW+1)-1:0] dout;
    logic                    vout;
    logic                    sout;

    if (k == 1) begin : g_first
      assign din = in_data;
      assign vin = in_valid;
      assign sin = in_signed;
    end else begin : g_next
      assign din = g_lvl[k-1].dout;
      assign vin = g_lvl[k-1].vout;
      assign sin = g_lvl[k-1].sout;
    end

    adder_tree_level #(
      .IW    (IW),
      .SEG   (SEG),
      .PAIRS (PAIRS)
    ) u_level (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .en_i     (en),
      .valid_i  (vin),
      .signed_i (sin),
      .data_i   (din),
      .valid_o  (vout),
      .signed_o (sout),
      .data_o   (dout)
    );
  end

  logic          last_v;
  logic          last_s;
  logic [OW-1:0] last_d;

  assign last_v = g_lvl[LVLS].vout;
  assign last_s = g_lvl[LVLS].sout;
  assign last_d = g_lvl[LVLS].dout;

  logic          out_valid_d, out_valid_q;
  logic          out_signed_d, out_signed_q;
  logic [OW-1:0] sum_d, sum_q;

  // sum and its tag only load on a valid result so they hold across bubbles.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_signed_d = out_signed_q;
    sum_d        = sum_q;
    if (en) begin
      out_valid_d = last_v;
      if (last_v) begin
        sum_d        = last_d;
        out_signed_d = last_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_signed_q <= 1'b0;
      sum_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_signed_q <= out_signed_d;
      sum_q        <= sum_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_signed = out_signed_q;
  assign sum        = sum_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
module tb_adder_tree_pipe;

  localparam int unsigned W    = 12;
  localparam int unsigned LVLS = 3;
  localparam int unsigned SEG  = 7;
  localparam int unsigned N    = 8;
  localparam int unsigned OW   = W + LVLS;
  localparam int          LAT  = 2 * LVLS;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            in_valid;
  logic            in_signed;
  logic [N*W-1:0]  in_data;
  logic            out_valid;
  logic [OW-1:0]   sum;
  logic            out_signed;

  adder_tree_pipe #(
    .W    (W),
    .LVLS (LVLS),
    .SEG  (SEG)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_signed  (in_signed),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .sum        (sum),
    .out_signed (out_signed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] val;
    logic          sg;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            total = 0;
  int            bad   = 0;
  int            ecnt  = 0;   // enabled, non-reset edges seen so far
  logic          exp_ov;
  logic [OW-1:0] exp_sum;
  logic          exp_sg;

  // Exact mathematical total in the sample's mode, truncated to the output width.
  function automatic logic [OW-1:0] ref_sum(input logic [N*W-1:0] d, input logic s);
    longint acc;
    logic [W-1:0] op;
    acc = 0;
    for (int i = 0; i < int'(N); i++) begin
      op = d[i*W +: W];
      if (s) acc += longint'($signed(op));
      else   acc += longint'(op);
    end
    return acc[OW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, update the model at posedge, check 1 time unit later.
  task automatic cyc(input logic r, input logic e, input logic v, input logic s,
                     input logic [N*W-1:0] d);
    @(negedge clk);
    rst_n = r; en = e; in_valid = v; in_signed = s; in_data = d;
    @(posedge clk);
    if (!r) begin
      sb.delete();
      exp_ov = 1'b0; exp_sum = '0; exp_sg = 1'b0;
    end else if (e) begin
      ecnt++;
      if (v) sb.push_back('{val: ref_sum(d, s), sg: s, due: ecnt + LAT});
      if (sb.size() > 0 && sb[0].due == ecnt) begin
        exp_ov = 1'b1; exp_sum = sb[0].val; exp_sg = sb[0].sg;
        void'(sb.pop_front());
      end else begin
        exp_ov = 1'b0;
      end
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("sum", 32'(sum), 32'(exp_sum));
    chk("out_signed", 32'(out_signed), 32'(exp_sg));
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic push(input logic s, input logic [N*W-1:0] d);
    cyc(1'b1, 1'b1, 1'b1, s, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'($urandom), rnd_data());
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'($urandom), 1'($urandom), rnd_data());
  endtask

  initial begin
    logic [N*W-1:0] ramp;
    logic [W-1:0]   pat;

    // Reset state
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Max positive signed
    pat = 12'h7FF;
    push(1'b1, {N{pat}});
    idle(LAT);
    chk("max_pos_signed", 32'(sum), 32'(15'h3FF8));
    chk("max_pos_signed_tag", 32'(out_signed), 32'd1);

    // Most negative, both modes back-to-back
    pat = 12'h800;
    push(1'b1, {N{pat}});
    push(1'b0, {N{pat}});
    idle(LAT - 1);
    chk("min_neg_signed", 32'(sum), 32'(15'h4000));
    idle(1);
    chk("h800_unsigned", 32'(sum), 32'(15'h4000));
    chk("h800_unsigned_tag", 32'(out_signed), 32'd0);

    // All ones: full carry chain in every level
    pat = 12'hFFF;
    push(1'b0, {N{pat}});
    push(1'b1, {N{pat}});
    idle(LAT - 1);
    chk("fff_unsigned", 32'(sum), 32'(15'h7FF8));
    idle(1);
    chk("fff_signed", 32'(sum), 32'(15'h7FF8));
    chk("fff_signed_tag", 32'(out_signed), 32'd1);

    // Ramp operand i = i*127, then 20 back-to-back random mixed-mode samples
    for (int i = 0; i < int'(N); i++) ramp[i*W +: W] = W'(i * 127);
    push(1'b1, ramp);
    push(1'b0, ramp);
    for (int i = 0; i < 20; i++) push(1'($urandom), rnd_data());
    idle(LAT);

    // Stall mid-stream (before and during output)
    push(1'b1, rnd_data());
    push(1'b0, rnd_data());
    stall(3);
    push(1'b1, rnd_data());
    push(1'b0, rnd_data());
    idle(LAT - 2);
    stall(3);
    idle(3);

    // Random enable / valid mix
    for (int i = 0; i < 40; i++)
      cyc(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), rnd_data());
    idle(LAT);

    // Reset with samples in flight, asserted while stalled to show priority over en
    for (int i = 0; i < 5; i++) push(1'($urandom), rnd_data());
    cyc(1'b0, 1'b0, 1'b1, 1'b1, rnd_data());
    chk("rst_flush_valid", 32'(out_valid), 32'd0);
    chk("rst_flush_sum", 32'(sum), 32'd0);
    idle(LAT);

    // Recovery after reset
    push(1'b1, ramp);
    idle(LAT);
    chk("ramp_after_rst", 32'(sum), 32'(15'd3556));

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
